// File: rtl/arb_escrita_pkg.sv
// arb_escrita_pkg: shared definitions for the register-bank write arbiter.
// Holds the default data/index widths, the register count, the round-robin
// pointer encoding and the write-command record (valid, register, data).
package arb_escrita_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 2;
  localparam int NREG       = 4;

  // Round-robin pointer: which requester wins when both are valid.
  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } ptr_e;

  // One write command towards the register bank, at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] reg_idx;
    logic [DATA_W_DEF-1:0] dado;
  } wr_cmd_t;

endpackage

// File: rtl/arb_escrita_if.sv
// arb_escrita_if: the two writeback request channels (0 = ALU, 1 = load).
//
// Handshake (both channels): a request transfers in a cycle where
// reqN_valid=1 and reqN_ready=1. While valid=1 and ready=0 the requester
// holds reqN_reg/reqN_dado stable. ready may depend combinationally on valid,
// and at most one ready is high in any cycle.
//
// Modports: master = requester side, slave = arbiter side.
interface arb_escrita_if #(
  parameter int DATA_W = arb_escrita_pkg::DATA_W_DEF,
  parameter int ADDR_W = arb_escrita_pkg::ADDR_W_DEF
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_dado;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_dado;

  modport master (
    output req0_valid, req0_reg, req0_dado,
    input  req0_ready,
    output req1_valid, req1_reg, req1_dado,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_reg, req0_dado,
    output req0_ready,
    input  req1_valid, req1_reg, req1_dado,
    output req1_ready
  );

endinterface

// File: rtl/arb_escrita_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer -> requester 0)
//   valid_i   - request vector, bit N = requester N
//   grant_o   - one-hot (or zero) grant, combinational on valid_i
//   ptr_o     - current round-robin pointer (debug / observation)
//
// When both requesters are valid the pointer picks the winner; after any
// grant the pointer moves to the loser, so a waiting requester is served on
// the very next cycle. No grant leaves the pointer where it was.
module rr_arb2
  import arb_escrita_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  output ptr_e       ptr_o
);

  ptr_e ptr_q;
  ptr_e ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_REQ0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (!rst) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (ptr_q == PTR_REQ0) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    if (grant_o[0]) begin
      ptr_d = PTR_REQ1;
    end else if (grant_o[1]) begin
      ptr_d = PTR_REQ0;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/arb_escrita_reg.sv
// arb_escrita_reg: arbitrates two writeback requesters onto a single
// register-bank write port and watches the bank's read indexes for
// read-after-write collisions with the write currently being issued.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req                 - arb_escrita_if.slave: requester 0/1 channels
//   reg_e, e_l, dado    - write command to the bank (e_l=1 means write)
//   fnt1, fnt2          - bank read indexes (observed only)
//   dado_l_1_in/_2_in   - raw read data from the bank
//   dado_l_1/_2         - read data towards the datapath
//   hazard              - read index matches the write being issued
//   dbg_ptr_o           - round-robin pointer, for observation
//
// Build option: define ARB_ESCRITA_BYPASS_EN to forward the issuing write
// data onto matching read ports (hazard then stays 0); without it the read
// data passes straight through and hazard flags the collision.
//
// Accepted requests land in a one-deep write stage and are issued the next
// cycle; the stage never stalls, so one write per cycle is sustained.
module arb_escrita_reg
  import arb_escrita_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  arb_escrita_if.slave      req,
  output logic [ADDR_W-1:0] reg_e,
  output logic              e_l,
  output logic [DATA_W-1:0] dado,
  input  logic [ADDR_W-1:0] fnt1,
  input  logic [ADDR_W-1:0] fnt2,
  input  logic [DATA_W-1:0] dado_l_1_in,
  input  logic [DATA_W-1:0] dado_l_2_in,
  output logic [DATA_W-1:0] dado_l_1,
  output logic [DATA_W-1:0] dado_l_2,
  output logic              hazard,
  output ptr_e              dbg_ptr_o
);

  logic [1:0] grant;

  logic              wr_v_q,    wr_v_d;
  logic [ADDR_W-1:0] wr_reg_q,  wr_reg_d;
  logic [DATA_W-1:0] wr_dado_q, wr_dado_d;

  logic issue_v;
  logic match1;
  logic match2;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i ({req.req1_valid, req.req0_valid}),
    .grant_o (grant),
    .ptr_o   (dbg_ptr_o)
  );

  // Grant doubles as ready: a granted valid request is accepted this cycle.
  assign req.req0_ready = grant[0];
  assign req.req1_ready = grant[1];

  always_comb begin
    wr_v_d    = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_dado_d = wr_dado_q;
    if (grant[0]) begin
      wr_v_d    = 1'b1;
      wr_reg_d  = req.req0_reg;
      wr_dado_d = req.req0_dado;
    end else if (grant[1]) begin
      wr_v_d    = 1'b1;
      wr_reg_d  = req.req1_reg;
      wr_dado_d = req.req1_dado;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_v_q    <= 1'b0;
      wr_reg_q  <= '0;
      wr_dado_q <= '0;
    end else begin
      wr_v_q    <= wr_v_d;
      wr_reg_q  <= wr_reg_d;
      wr_dado_q <= wr_dado_d;
    end
  end

  // The stage is masked by rst combinationally: a write captured on the edge
  // just before reset rises must not reach the bank at the reset edge.
  assign issue_v = wr_v_q & ~rst;
  assign e_l     = issue_v;
  assign reg_e   = rst ? '0 : wr_reg_q;
  assign dado    = rst ? '0 : wr_dado_q;

  assign match1 = issue_v && (fnt1 == wr_reg_q);
  assign match2 = issue_v && (fnt2 == wr_reg_q);

`ifdef ARB_ESCRITA_BYPASS_EN
  assign dado_l_1 = match1 ? wr_dado_q : dado_l_1_in;
  assign dado_l_2 = match2 ? wr_dado_q : dado_l_2_in;
  assign hazard   = 1'b0;
`else
  assign dado_l_1 = dado_l_1_in;
  assign dado_l_2 = dado_l_2_in;
  assign hazard   = match1 | match2;
`endif

endmodule

// File: tb/tb_arb_escrita_reg.sv
// tb_arb_escrita_reg: self-checking bench for arb_escrita_reg.
// Directed scenarios first, then randomized requests with occasional resets,
// all checked against a transaction-level model of the arbiter.
module tb_arb_escrita_reg;
  import arb_escrita_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int W      = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_escrita_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rif ();

  logic [ADDR_W-1:0] reg_e, fnt1, fnt2;
  logic              e_l, hazard;
  logic [DATA_W-1:0] dado, dado_l_1_in, dado_l_2_in, dado_l_1, dado_l_2;
  ptr_e              dbg_ptr;

  arb_escrita_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (rif),
    .reg_e       (reg_e),
    .e_l         (e_l),
    .dado        (dado),
    .fnt1        (fnt1),
    .fnt2        (fnt2),
    .dado_l_1_in (dado_l_1_in),
    .dado_l_2_in (dado_l_2_in),
    .dado_l_1    (dado_l_1),
    .dado_l_2    (dado_l_2),
    .hazard      (hazard),
    .dbg_ptr_o   (dbg_ptr)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]      exp_q[$];          // accepted writes awaiting issue
  int                pref = 0;          // requester preferred on a tie
  logic [DATA_W-1:0] bank_exp[NREG];
  logic [DATA_W-1:0] bank_dut[NREG];
  int                dut_wr_cnt = 0;
  int                wait0 = 0, wait1 = 0;
  logic              acc0, acc1;
  logic              obs_ready0, obs_ready1, obs_hazard;
  logic [DATA_W-1:0] obs_dado_l_1;

  // ---------------- driver ----------------
  task automatic drive_req(input int n, input logic v, input logic [ADDR_W-1:0] r,
                           input logic [DATA_W-1:0] d);
    if (n == 0) begin
      rif.req0_valid = v; rif.req0_reg = r; rif.req0_dado = d;
    end else begin
      rif.req1_valid = v; rif.req1_reg = r; rif.req1_dado = d;
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model
  // across the rising edge. Inputs must already be driven.
  task automatic run_cycle();
    logic    eg0, eg1, ewv, m1, m2, v0, v1;
    wr_cmd_t cmd;
    @(negedge clk);
    v0  = rif.req0_valid;
    v1  = rif.req1_valid;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (v0 && v1) begin
        eg0 = (pref == 0);
        eg1 = (pref == 1);
      end else begin
        eg0 = v0;
        eg1 = v1;
      end
    end
    check_eq("req0_ready", rif.req0_ready, eg0);
    check_eq("req1_ready", rif.req1_ready, eg1);
    obs_ready0 = rif.req0_ready;
    obs_ready1 = rif.req1_ready;

    ewv = !rst && (exp_q.size() != 0);
    cmd = '0;
    if (ewv) cmd = wr_cmd_t'({1'b1, exp_q[0]});
    check_eq("e_l", e_l, ewv);
    if (ewv || rst) begin
      check_eq("reg_e", reg_e, cmd.reg_idx);
      check_eq("dado", dado, cmd.dado);
    end

    m1 = ewv && (fnt1 == cmd.reg_idx);
    m2 = ewv && (fnt2 == cmd.reg_idx);
`ifdef ARB_ESCRITA_BYPASS_EN
    check_eq("hazard", hazard, 1'b0);
    check_eq("dado_l_1", dado_l_1, m1 ? cmd.dado : dado_l_1_in);
    check_eq("dado_l_2", dado_l_2, m2 ? cmd.dado : dado_l_2_in);
`else
    check_eq("hazard", hazard, m1 | m2);
    check_eq("dado_l_1", dado_l_1, dado_l_1_in);
    check_eq("dado_l_2", dado_l_2, dado_l_2_in);
`endif
    obs_hazard   = hazard;
    obs_dado_l_1 = dado_l_1;

    if (!rst) check_eq("ptr", dbg_ptr, pref);

    // No starvation: a valid requester waits at most one cycle.
    if (!rst && v0) begin
      wait0 = rif.req0_ready ? 0 : wait0 + 1;
      check_eq("wait0_bound", wait0 <= 1, 1'b1);
    end else wait0 = 0;
    if (!rst && v1) begin
      wait1 = rif.req1_ready ? 0 : wait1 + 1;
      check_eq("wait1_bound", wait1 <= 1, 1'b1);
    end else wait1 = 0;

    if (e_l) begin
      bank_dut[reg_e] = dado;
      dut_wr_cnt++;
    end

    @(posedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      exp_q.delete();
      pref = 0;
    end else begin
      if (ewv) begin
        void'(exp_q.pop_front());
        bank_exp[cmd.reg_idx] = cmd.dado;
      end
      acc0 = eg0;
      acc1 = eg1;
      if (acc0) begin exp_q.push_back({rif.req0_reg, rif.req0_dado}); pref = 1; end
      if (acc1) begin exp_q.push_back({rif.req1_reg, rif.req1_dado}); pref = 0; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_req(0, 1'b1, ADDR_W'($urandom_range(0, 3)), $urandom);
    drive_req(1, 1'b1, ADDR_W'($urandom_range(0, 3)), $urandom);
    run_cycle();
    run_cycle();
    rst = 1'b0;
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_before;
    for (int i = 0; i < NREG; i++) begin
      bank_exp[i] = '0;
      bank_dut[i] = '0;
    end
    fnt1 = '0; fnt2 = '0; dado_l_1_in = '0; dado_l_2_in = '0;
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    // Single write from requester 0.
    do_reset();
    drive_req(0, 1'b1, 2'd1, 32'hA5A5_A5A5);
    run_cycle();
    check_eq("single_ready0", obs_ready0, 1'b1);
    drive_req(0, 1'b0, '0, '0);
    run_cycle();
    check_eq("single_reg1", bank_dut[1], 32'hA5A5_A5A5);
    run_cycle();

    // Both valid continuously: grants alternate 0,1,0,1.
    do_reset();
    drive_req(0, 1'b1, 2'd2, 32'h11);
    drive_req(1, 1'b1, 2'd3, 32'h22);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check_eq("rr_grant1", obs_ready1, (i % 2) == 1);
    end
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    run_cycle();
    run_cycle();

    // Same target register: last granted value wins.
    do_reset();
    drive_req(0, 1'b1, 2'd0, 32'h1);
    drive_req(1, 1'b1, 2'd0, 32'h2);
    run_cycle();
    drive_req(0, 1'b0, '0, '0);
    run_cycle();
    drive_req(1, 1'b0, '0, '0);
    run_cycle();
    run_cycle();
    check_eq("same_reg_final", bank_dut[0], 32'h2);

    // Read collision with the issuing write.
    do_reset();
    fnt1 = 2'd2; fnt2 = 2'd3;
    drive_req(0, 1'b1, 2'd1, 32'hDEAD_BEEF);
    run_cycle();
    drive_req(0, 1'b0, '0, '0);
    fnt1 = 2'd1; dado_l_1_in = '0;
    run_cycle();
`ifdef ARB_ESCRITA_BYPASS_EN
    check_eq("raw_dado_l_1", obs_dado_l_1, 32'hDEAD_BEEF);
    check_eq("raw_hazard", obs_hazard, 1'b0);
`else
    check_eq("raw_dado_l_1", obs_dado_l_1, 32'h0);
    check_eq("raw_hazard", obs_hazard, 1'b1);
`endif
    fnt1 = '0;

    // Reset right after an acceptance discards the pending write.
    do_reset();
    drive_req(1, 1'b1, 2'd2, 32'h55);
    run_cycle();
    cnt_before = dut_wr_cnt;
    rst = 1'b1;
    run_cycle();
    check_eq("rst_ready1", obs_ready1, 1'b0);
    run_cycle();
    check_eq("rst_no_write", dut_wr_cnt, cnt_before);
    rst = 1'b0;
    drive_req(1, 1'b0, '0, '0);
    run_cycle();
    check_eq("rst_ptr", dbg_ptr, PTR_REQ0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (!(rif.req0_valid && !acc0) || rst) begin
        drive_req(0, $urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 3)), $urandom);
      end
      if (!(rif.req1_valid && !acc1) || rst) begin
        drive_req(1, $urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 3)), $urandom);
      end
      rst         = ($urandom_range(0, 99) == 0);
      fnt1        = ADDR_W'($urandom_range(0, 3));
      fnt2        = ADDR_W'($urandom_range(0, 3));
      dado_l_1_in = $urandom;
      dado_l_2_in = $urandom;
      run_cycle();
    end
    rst = 1'b0;
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    run_cycle();
    run_cycle();

    for (int i = 0; i < NREG; i++) begin
      check_eq($sformatf("bank_final%0d", i), bank_dut[i], bank_exp[i]);
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_escrita_reg.md
ARB_ESCRITA_REG -- requirements
Module: arb_escrita_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of register data.
REQ-002 Parameter ADDR_W, default 2: width of register index (4 registers).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports req0_valid in 1, req0_ready out 1, req0_reg in ADDR_W, req0_dado in DATA_W: requester 0 (ALU writeback) write request.
REQ-006 Ports req1_valid in 1, req1_ready out 1, req1_reg in ADDR_W, req1_dado in DATA_W: requester 1 (memory/load writeback) write request.
REQ-007 Ports reg_e out ADDR_W, e_l out 1, dado out DATA_W: write command to the register bank; e_l=1 means write.
REQ-008 Ports fnt1 in ADDR_W, fnt2 in ADDR_W: read indexes driven to the bank, observed here.
REQ-009 Ports dado_l_1_in in DATA_W, dado_l_2_in in DATA_W: raw read data from the bank.
REQ-010 Ports dado_l_1 out DATA_W, dado_l_2 out DATA_W, hazard out 1: read data to the datapath and read-after-write hazard flag.

Function
REQ-011 Handshake: a request is accepted in a cycle where reqN_valid=1 and reqN_ready=1; requester holds reg/dado stable while valid=1 and ready=0.
REQ-012 At most one of req0_ready/req1_ready is 1 per cycle; readiness may depend combinationally on valid.
REQ-013 Arbitration: round-robin pointer ptr; both valid -> grant requester ptr; one valid -> grant it; none valid -> no grant.
REQ-014 After any grant, ptr updates to the non-granted requester index; no grant leaves ptr unchanged.
REQ-015 Accepted request is captured into a write stage (wr_v, wr_reg, wr_dado) at the accepting edge.
REQ-016 Write stage drives reg_e=wr_reg, dado=wr_dado, e_l=wr_v; latency accept-to-e_l is exactly 1 cycle; e_l is high exactly 1 cycle per accepted request.
REQ-017 Write stage is never blocked; throughput 1 write per cycle; wr_v=0 in cycles with no acceptance.
REQ-018 Both requesters targeting the same register: serialized in grant order; last granted value is final bank content.
REQ-019 A requester not granted for 1 cycle while the other is valid is granted on the next cycle (max wait 1 cycle, no starvation).
REQ-020 Read match: match1 = wr_v and fnt1==wr_reg; match2 likewise for fnt2.

Reset
REQ-021 While rst=1: req0_ready=0, req1_ready=0, no request accepted.
REQ-022 At a clock edge with rst=1: wr_v=0, wr_reg=0, wr_dado=0, ptr=0 (requester 0 preferred first).
REQ-023 Reset outputs: e_l=0, reg_e=0, dado=0, hazard=0; a write pending in the stage is discarded, not issued.

Configuration
REQ-024 Macro ARB_ESCRITA_BYPASS_EN defined: dado_l_k = wr_dado when matchk, else dado_l_k_in; hazard tied 0.
REQ-025 Macro not defined: dado_l_k = dado_l_k_in unconditionally; hazard = match1 or match2, combinational.

Structure
REQ-026 Shared package arb_escrita_pkg holds DATA_W/ADDR_W defaults, NREG=4, and a write-command struct type (valid, reg, dado).
REQ-027 One sub-module, rr_arb2: 2-requester round-robin arbiter (valid in, grant out, ptr state); remaining logic inline.

Verification
REQ-028 Reset then req0 valid reg=1 dado=0xA5A5A5A5 -> req0_ready=1 same cycle; next cycle e_l=1, reg_e=1, dado=0xA5A5A5A5; following cycle e_l=0.
REQ-029 Both valid continuously from reset, req0 reg=2 dado=0x11, req1 reg=3 dado=0x22 -> grants alternate 0,1,0,1; e_l high every cycle, reg_e 2,3,2,3.
REQ-030 Both valid same reg=0, req0 dado=0x1, req1 dado=0x2, ptr=0 -> writes issue 0x1 then 0x2; bank reg0 ends 0x2.
REQ-031 Write stage reg=1 dado=0xDEADBEEF, fnt1=1, dado_l_1_in=0 -> with macro dado_l_1=0xDEADBEEF, hazard=0; without macro dado_l_1=0, hazard=1.
REQ-032 req1 accepted at edge N, rst=1 at edge N+1 -> e_l=0 after edge N+1, no write to bank, ptr=0, readies 0 while rst=1.
